mem_responder: RTL and testbench



---
 rtl/mem_responder.sv | 126 ++++++++++++
 tb/tb_mem_responder.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: word-wide memory target with a programmable number of wait
// states, serving a req/ready memory port. One request is latched in IDLE, the
// wait counter runs, the access is committed on the edge that enters RESP, and
// ready/err pulse for exactly one cycle.
//
// Optional feature: define MEM_ALIGN_CHECK_EN to flag any request whose byte
// address is not word aligned as an error, handled exactly like an
// out-of-range access. Without the macro the low two address bits are ignored.
module mem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT        = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // The counter is loaded with WAIT+1 so that the edge on which it reads 1
    // is exactly WAIT+1 edges after acceptance, which also covers WAIT=0.
    localparam logic [4:0] COUNT_LOAD = 5'(WAIT + 1);

    logic [1:0]    state;
    logic [4:0]    count;
    logic          latWe;
    logic          latErr;
    logic [AW-1:0] latIdx;
    logic [31:0]   latWdata;
    logic [31:0]   mem [DEPTH_WORDS];

    logic outOfRange;
    logic misaligned;
    logic enterResp;

    assign outOfRange = |addr[31:AW+2];

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = |addr[1:0];
`else
    logic unusedAddrBits;
    assign unusedAddrBits = ^addr[1:0];
    assign misaligned     = 1'b0;
`endif

    assign enterResp = (state == S_WAIT) && (count == 5'd1);

    // Control FSM: accept and latch a request, count wait states, pulse ready/err.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            count    <= '0;
            latWe    <= 1'b0;
            latErr   <= 1'b0;
            latIdx   <= '0;
            latWdata <= '0;
            ready    <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
        end else begin
            ready <= 1'b0;
            err   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        latWe    <= we;
                        latErr   <= outOfRange | misaligned;
                        latIdx   <= addr[AW+1:2];
                        latWdata <= wdata;
                        count    <= COUNT_LOAD;
                        state    <= S_WAIT;
                        busy     <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (count == 5'd1) begin
                        count <= '0;
                        state <= S_RESP;
                        ready <= 1'b1;
                        err   <= latErr;
                    end else begin
                        count <= count - 5'd1;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Storage and read register: commit the write or fetch the word on RESP entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= '0;
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (enterResp) begin
            if (latErr) begin
                rdata <= '0;
            end else if (latWe) begin
                mem[latIdx] <= latWdata;
            end else begin
                rdata <= mem[latIdx];
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized and directed stimulus for mem_responder with a
// response scoreboard. A reference model decides which requests are accepted
// from the documented timing, applies them to an array and queues the expected
// response; an independent monitor pops and compares on every ready pulse.
// Honours MEM_ALIGN_CHECK_EN the same way the design does.
module tb_mem_responder;

    localparam int DEPTH = 64;
    localparam int WAITS = 2;

    logic        clk;
    logic        reset;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        busy;
    logic        err;

    typedef struct {
        int          expEdge;
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    resp_t       scoreQ[$];
    logic [31:0] refMem [DEPTH];
    logic [31:0] lastRdata   = '0;
    int          edgeNum     = 0;
    int          nextFree    = 0;
    int          busyFrom    = 0;
    int          busyTo      = 0;
    bit          hasAcc      = 0;
    int          acceptCount = 0;

    int errors = 0;
    int checks = 0;

    mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT(WAITS)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .ready (ready),
        .busy  (busy),
        .err   (err)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", name, edgeNum, actual, expected);
        end
    endtask

    // Reference model: a request is taken when req is high and the previous
    // transaction has fully drained (earliest WAIT+3 edges after the last one).
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) refMem[i] = '0;
            lastRdata = '0;
            scoreQ.delete();
            hasAcc   = 0;
            nextFree = 0;
        end else begin
            edgeNum++;
            if (req && edgeNum >= nextFree) begin
                logic [31:0] wordIdx;
                bit          bad;
                wordIdx = {2'b00, addr[31:2]};
                bad     = (wordIdx >= 32'(DEPTH));
`ifdef MEM_ALIGN_CHECK_EN
                if (addr[1:0] != 2'b00) bad = 1;
`endif
                if (bad) lastRdata = '0;
                else if (we) refMem[int'(wordIdx)] = wdata;
                else lastRdata = refMem[int'(wordIdx)];
                scoreQ.push_back('{expEdge: edgeNum + WAITS + 1, rdata: lastRdata, err: bad});
                busyFrom = edgeNum;
                busyTo   = edgeNum + WAITS + 1;
                hasAcc   = 1;
                nextFree = edgeNum + WAITS + 3;
                acceptCount++;
            end
        end
    end

    // Monitor: compare outputs mid-cycle against the model's expectations.
    always @(negedge clk) begin
        if (reset) begin
            checkOutput("resetOutputs", 64'({ready, busy, err, rdata}), 64'd0);
        end else begin
            checkOutput("busy", 64'(busy), 64'(hasAcc && edgeNum >= busyFrom && edgeNum <= busyTo));
            if (scoreQ.size() > 0 && scoreQ[0].expEdge < edgeNum) begin
                checks++;
                errors++;
                $display("[TB] FAIL readyMissing at edge %0d: got no pulse, expected one at edge %0d", edgeNum, scoreQ[0].expEdge);
                void'(scoreQ.pop_front());
            end
            if (ready) begin
                if (scoreQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL readyUnexpected at edge %0d: got ready=1, expected 0", edgeNum);
                end else begin
                    resp_t exp;
                    exp = scoreQ.pop_front();
                    checkOutput("readyEdge", 64'(edgeNum), 64'(exp.expEdge));
                    checkOutput("rdata", 64'(rdata), 64'(exp.rdata));
                    checkOutput("err", 64'(err), 64'(exp.err));
                end
            end else if (err) begin
                checks++;
                errors++;
                $display("[TB] FAIL errWithoutReady at edge %0d: got err=1, expected 0", edgeNum);
            end
        end
    end

    // Drive one request and hold it until the model reports acceptance.
    task automatic applyStimulus(input logic isWrite, input logic [31:0] a, input logic [31:0] d);
        int startCount;
        int budget;
        startCount = acceptCount;
        budget     = 0;
        @(posedge clk);
        #1;
        req   = 1'b1;
        we    = isWrite;
        addr  = a;
        wdata = d;
        do begin
            @(posedge clk);
            #1;
            budget++;
        end while (acceptCount == startCount && budget < 40);
        req = 1'b0;
        if (acceptCount == startCount) begin
            checks++;
            errors++;
            $display("[TB] FAIL acceptTimeout: got no acceptance in %0d cycles, expected one", budget);
        end
    endtask

    task automatic waitDrain();
        int budget;
        budget = 0;
        while ((scoreQ.size() > 0 || edgeNum < nextFree) && budget < 100) begin
            @(posedge clk);
            #1;
            budget++;
        end
        if (scoreQ.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drainTimeout: got %0d responses pending, expected 0", scoreQ.size());
        end
    endtask

    function automatic logic [31:0] randomAddr();
        int unsigned r;
        r = $urandom_range(0, 7);
        if (r <= 4) return {27'd0, 3'($urandom_range(0, 7)), 2'b00};
        if (r == 5) return {27'd0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
        if (r == 6) return 32'h400 + 32'($urandom_range(0, 255));
        return $urandom;
    endfunction

    initial begin
        reset = 1'b1;
        req   = 1'b0;
        we    = 1'b0;
        addr  = '0;
        wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Directed sequence from the documented scenarios.
        applyStimulus(1'b0, 32'h10, 32'h0);
        waitDrain();
        applyStimulus(1'b1, 32'h20, 32'hDEADBEEF);
        waitDrain();
        applyStimulus(1'b0, 32'h20, 32'h0);
        waitDrain();
        applyStimulus(1'b1, 32'h0, 32'hA5A5_0001);
        waitDrain();
        applyStimulus(1'b0, 32'h400, 32'h0);
        waitDrain();
        applyStimulus(1'b0, 32'h0, 32'h0);
        waitDrain();
        applyStimulus(1'b1, 32'h22, 32'h12345678);
        waitDrain();
        applyStimulus(1'b0, 32'h20, 32'h0);
        waitDrain();

        // Reset one cycle after a write is accepted: outputs clear at once.
        applyStimulus(1'b1, 32'h30, 32'hCAFE_F00D);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("asyncReset", 64'({ready, busy, err, rdata}), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(1'b0, 32'h30, 32'h0);
        waitDrain();

        // req held high with changing fields: only idle-cycle requests count.
        for (int i = 0; i < 24; i++) begin
            @(posedge clk);
            #1;
            req   = 1'b1;
            we    = 1'($urandom_range(0, 1));
            addr  = randomAddr();
            wdata = $urandom;
        end
        @(posedge clk);
        #1;
        req = 1'b0;
        waitDrain();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            req   = ($urandom_range(0, 2) != 0);
            we    = 1'($urandom_range(0, 1));
            addr  = randomAddr();
            wdata = $urandom;
        end
        @(posedge clk);
        #1;
        req = 1'b0;
        waitDrain();
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
